frame_stream_arbiter: RTL and testbench
=======================================

// Module: frame_stream_arbiter
// PURPOSE
//  Merges the framed 64-bit output streams of N_CH per-channel data-frame generators into one stream for the
//  readout link. Grants whole frames round-robin (header..footer never interleaved), checks header/footer IDs
//  and length, and drives a registered valid/ready output stage. Sits between channel generators and packer.
// PARAMETERS
//  N_CH         4        number of input channels (2..16)
//  DOUT_WIDTH   64       word width, in and out
//  LEN_WIDTH    9        width of payload-length field in header bits [LEN_WIDTH-1:0]
//  MAX_PAYLOAD  200      largest legal payload length (words, excl. header/footer)
//  HEADER_ID    16'hAAAA header marker, DIN[DOUT_WIDTH-1 -:16]
//  FOOTER_ID    16'h5555 footer marker, DIN[15:0]
// PORTS
//  CLK       in   1                  clock; all logic on posedge
//  RESET     in   1                  asynchronous, active-high reset
//  iVALID    in   N_CH               per-channel word valid
//  DIN       in   N_CH*DOUT_WIDTH    per-channel words; channel k at [k*DOUT_WIDTH +:DOUT_WIDTH]
//  oREADY    out  N_CH               per-channel accept; word k consumed when iVALID[k]&oREADY[k]
//  oVALID    out  1                  merged word valid (registered)
//  DOUT      out  DOUT_WIDTH         merged word (registered)
//  iREADY    in   1                  downstream accept
//  oLAST     out  1                  DOUT is the footer word of the current frame
//  CUR_CH    out  clog2(N_CH)        channel owning the word on DOUT
//  PROTO_ERR out  1                  one-cycle pulse on any protocol violation
// BEHAVIOUR
//  Reset (async): state=IDLE, rr pointer=N_CH-1, oVALID=0, DOUT=all ones, oLAST=0, CUR_CH=0, PROTO_ERR=0, oREADY=0.
//  Output stage: load_en = !oVALID | iREADY. Only loaded from the granted channel; DOUT/oVALID/oLAST update on load_en.
//  States: IDLE -> HEAD -> BODY -> FOOT -> IDLE.
//  IDLE: candidates = channels with iVALID and DIN top 16 bits == HEADER_ID. Pick first candidate after rr pointer
//   (wrapping). Register grant g, set rr pointer=g, go HEAD. oREADY=0 for all candidates in this cycle.
//   Valid non-header words on any channel in IDLE: flushed (oREADY[k]=1), PROTO_ERR pulses once per cycle.
//   No candidates: stay IDLE.
//  HEAD/BODY/FOOT: oREADY[g]=load_en; oREADY of other channels=0. Word transfers only when iVALID[g]&load_en.
//  HEAD: on transfer, latch len=DIN[LEN_WIDTH-1:0]. len>MAX_PAYLOAD -> len clamped to MAX_PAYLOAD, PROTO_ERR.
//   len==0 -> FOOT, else BODY with cnt=0.
//  BODY: each transfer cnt++; transfer with cnt==len-1 -> FOOT. HEADER_ID seen in body is passed as data.
//  FOOT: on transfer oLAST=1 with that word; DIN[15:0]!=FOOTER_ID -> PROTO_ERR (word still forwarded). -> IDLE.
//  Frame occupies len+2 words; one IDLE cycle minimum between frames; back-to-back frames of same channel allowed
//   but only if no other candidate exists at the IDLE decision.
//  iVALID[g] low mid-frame: stall, grant held indefinitely (no timeout). iREADY low: oVALID/DOUT held stable.
//  CUR_CH = g captured with each loaded word. PROTO_ERR from IDLE and from active states in the same cycle -> one pulse.
//  Reset mid-frame: frame abandoned; after reset the remainder on that channel is flushed as non-header words.
// TESTING
//  1) ch0 only: header len=3 (DIN=AAAA..0003), 3 data, footer ..5555 -> 5 words out in order, oLAST on 5th, CUR_CH=0.
//  2) ch0..3 all hold headers simultaneously, iREADY=1 -> frames emitted in order ch0,ch1,ch2,ch3, never interleaved.
//  3) iREADY toggled 1-0-1 every cycle during frame -> no word lost/duplicated, DOUT stable while oVALID&!iREADY.
//  4) header len=250 -> PROTO_ERR pulse, 200 payload words forwarded, 202nd word carries oLAST.
//  5) ch2 sends 0x1234 word with no header in IDLE -> oREADY[2]=1, PROTO_ERR=1 one cycle, nothing on DOUT.
//  6) assert RESET mid-BODY -> oVALID=0, DOUT=all ones within same cycle; next header on ch1 granted cleanly.

Source files
------------

// File: rtl/frame_stream_arbiter_if.sv
// ---------------------------------------------------------------------------
// frame_stream_arbiter_if
//   Bundles the per-channel input streams and the merged output stream of
//   frame_stream_arbiter.
//   slave  : arbiter side (consumes iVALID/DIN/iREADY, drives the rest)
//   master : environment side (channel generators + downstream packer)
//   iVALID/DIN/oREADY : per-channel valid/ready, channel k at DIN[k*DOUT_WIDTH +: DOUT_WIDTH]
//   oVALID/DOUT/iREADY: merged registered output handshake
//   oLAST             : DOUT is the footer of the current frame
//   CUR_CH            : channel owning the word on DOUT
//   PROTO_ERR         : one-cycle protocol violation pulse
// ---------------------------------------------------------------------------
interface frame_stream_arbiter_if #(
    parameter int N_CH       = 4,
    parameter int DOUT_WIDTH = 64
);
    logic [N_CH-1:0]            iVALID;
    logic [N_CH*DOUT_WIDTH-1:0] DIN;
    logic [N_CH-1:0]            oREADY;
    logic                       oVALID;
    logic [DOUT_WIDTH-1:0]      DOUT;
    logic                       iREADY;
    logic                       oLAST;
    logic [$clog2(N_CH)-1:0]    CUR_CH;
    logic                       PROTO_ERR;

    modport slave (
        input  iVALID, DIN, iREADY,
        output oREADY, oVALID, DOUT, oLAST, CUR_CH, PROTO_ERR
    );

    modport master (
        output iVALID, DIN, iREADY,
        input  oREADY, oVALID, DOUT, oLAST, CUR_CH, PROTO_ERR
    );
endinterface

// File: rtl/frame_stream_arbiter.sv
// ---------------------------------------------------------------------------
// frame_stream_arbiter
//   Merges N_CH framed word streams (header, len payload words, footer) into
//   one registered valid/ready stream. Whole frames are granted round-robin,
//   header length is range-checked and clamped, the footer marker is checked,
//   and stray non-header words seen while idle are flushed.
//   CLK   : clock, posedge
//   RESET : asynchronous, active-high
//   bus   : frame_stream_arbiter_if.slave (input streams + merged output)
// ---------------------------------------------------------------------------
module frame_stream_arbiter #(
    parameter int                N_CH        = 4,
    parameter int                DOUT_WIDTH  = 64,
    parameter int                LEN_WIDTH   = 9,
    parameter int                MAX_PAYLOAD = 200,
    parameter logic [15:0]       HEADER_ID   = 16'hAAAA,
    parameter logic [15:0]       FOOTER_ID   = 16'h5555
) (
    input  logic                  CLK,
    input  logic                  RESET,
    frame_stream_arbiter_if.slave bus
);
    localparam int CW = $clog2(N_CH);

    typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_FOOT} state_t;

    state_t                 r_state, w_next;
    logic [CW-1:0]          r_g, r_rr, w_pick;
    logic                   w_found;
    logic [LEN_WIDTH-1:0]   r_len, r_cnt;
    logic [LEN_WIDTH-1:0]   w_hd_len, w_len_clamped;
    logic                   w_len_ovf;
    logic [N_CH-1:0]        w_cand, w_junk, w_oready;
    logic [DOUT_WIDTH-1:0]  w_din_g;
    logic                   w_load_en, w_xfer, w_err;

    logic                   r_ovalid, r_olast, r_err;
    logic [DOUT_WIDTH-1:0]  r_dout;
    logic [CW-1:0]          r_cur;

    assign w_din_g   = bus.DIN[r_g*DOUT_WIDTH +: DOUT_WIDTH];
    assign w_load_en = !r_ovalid | bus.iREADY;
    assign w_xfer    = (r_state != S_IDLE) & bus.iVALID[r_g] & w_load_en;

    assign w_hd_len      = w_din_g[LEN_WIDTH-1:0];
    assign w_len_ovf     = w_hd_len > LEN_WIDTH'(MAX_PAYLOAD);
    assign w_len_clamped = w_len_ovf ? LEN_WIDTH'(MAX_PAYLOAD) : w_hd_len;

    // Split idle-time valid words into header candidates and junk to flush.
    always_comb begin
        w_cand = '0;
        w_junk = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (bus.iVALID[k]) begin
                if (bus.DIN[k*DOUT_WIDTH + DOUT_WIDTH-1 -: 16] == HEADER_ID)
                    w_cand[k] = 1'b1;
                else
                    w_junk[k] = 1'b1;
            end
        end
    end

    // Round-robin: first candidate strictly after the last grant, wrapping,
    // so the last granted channel only wins again if it is alone.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = (int'(r_rr) + i) % N_CH;
            if (!w_found && w_cand[idx]) begin
                w_found = 1'b1;
                w_pick  = idx[CW-1:0];
            end
        end
    end

    // Next state / per-channel ready / error. Idle and active errors can
    // never coincide because they come from different states, so a single
    // flag gives one pulse per cycle.
    always_comb begin
        w_next   = r_state;
        w_oready = '0;
        w_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_oready = w_junk;
                w_err    = |w_junk;
                if (w_found) w_next = S_HEAD;
            end
            S_HEAD: begin
                w_oready[r_g] = w_load_en;
                if (w_xfer) begin
                    w_err  = w_len_ovf;
                    w_next = (w_len_clamped == '0) ? S_FOOT : S_BODY;
                end
            end
            S_BODY: begin
                w_oready[r_g] = w_load_en;
                if (w_xfer && (r_cnt == r_len - 1'b1)) w_next = S_FOOT;
            end
            S_FOOT: begin
                w_oready[r_g] = w_load_en;
                if (w_xfer) begin
                    w_err  = (w_din_g[15:0] != FOOTER_ID);
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        // Nothing is consumed while reset is held.
        if (RESET) begin
            w_oready = '0;
            w_err    = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_g     <= '0;
            r_rr    <= CW'(N_CH-1);
            r_len   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_err;
            if (r_state == S_IDLE && w_found) begin
                r_g  <= w_pick;
                r_rr <= w_pick;
            end
            if (w_xfer && r_state == S_HEAD) begin
                r_len <= w_len_clamped;
                r_cnt <= '0;
            end else if (w_xfer && r_state == S_BODY) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Output register: loads only with a word from the granted channel;
    // drains (valid drops) when the slot is free and nothing arrives.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_ovalid <= 1'b0;
            r_dout   <= '1;
            r_olast  <= 1'b0;
            r_cur    <= '0;
        end else if (w_xfer) begin
            r_ovalid <= 1'b1;
            r_dout   <= w_din_g;
            r_olast  <= (r_state == S_FOOT);
            r_cur    <= r_g;
        end else if (w_load_en) begin
            r_ovalid <= 1'b0;
            r_olast  <= 1'b0;
        end
    end

    assign bus.oREADY    = w_oready;
    assign bus.oVALID    = r_ovalid;
    assign bus.DOUT      = r_dout;
    assign bus.oLAST     = r_olast;
    assign bus.CUR_CH    = r_cur;
    assign bus.PROTO_ERR = r_err;
endmodule

// File: tb/tb_frame_stream_arbiter.sv
module tb_frame_stream_arbiter;
    localparam int N = 4;
    localparam int W = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frame_stream_arbiter_if #(.N_CH(N), .DOUT_WIDTH(W)) bus ();

    frame_stream_arbiter #(
        .N_CH(N), .DOUT_WIDTH(W), .LEN_WIDTH(9), .MAX_PAYLOAD(200),
        .HEADER_ID(16'hAAAA), .FOOTER_ID(16'h5555)
    ) dut (
        .CLK  (clk),
        .RESET(rst),
        .bus  (bus)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic         last;
        logic [1:0]   ch;
    } exp_t;

    exp_t         expq[$];
    logic [W-1:0] chq[N][$];
    logic [N-1:0] acc = '0;
    int           acc_cnt[N];
    int           n_tests = 0, n_fail = 0, err_seen = 0, out_cnt = 0;
    logic         toggle = 1'b0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_dout = '0;

    task automatic chk(input string nm, input logic [W-1:0] a, input logic [W-1:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Monitor / scoreboard: samples on the falling edge, away from updates.
    always @(negedge clk) begin
        if (!rst) begin
            acc = bus.iVALID & bus.oREADY;
            if (bus.PROTO_ERR) err_seen++;
            if (prev_stall && bus.oVALID) begin
                n_tests++;
                if (bus.DOUT !== prev_dout) begin
                    n_fail++;
                    $display("FAIL stall_hold: got %h expected %h", bus.DOUT, prev_dout);
                end
            end
            prev_stall = bus.oVALID && !bus.iREADY;
            prev_dout  = bus.DOUT;
            if (bus.oVALID && bus.iREADY) begin
                n_tests++;
                out_cnt++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_word: got %h expected none", bus.DOUT);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    if (bus.DOUT !== e.d || bus.oLAST !== e.last || bus.CUR_CH !== e.ch) begin
                        n_fail++;
                        $display("FAIL out_word: got d=%h last=%b ch=%0d expected d=%h last=%b ch=%0d",
                                 bus.DOUT, bus.oLAST, bus.CUR_CH, e.d, e.last, e.ch);
                    end
                end
            end
        end else begin
            acc        = '0;
            prev_stall = 1'b0;
        end
    end

    // Channel drivers: pop accepted words, present queue fronts, drive iREADY.
    initial begin
        bus.iVALID = '0;
        bus.DIN    = '0;
        bus.iREADY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (acc[k] && chq[k].size() > 0) begin
                    chq[k].delete(0);
                    acc_cnt[k]++;
                end
                bus.iVALID[k]       = (chq[k].size() > 0);
                bus.DIN[k*W +: W]   = (chq[k].size() > 0) ? chq[k][0] : '0;
            end
            bus.iREADY = toggle ? ~bus.iREADY : 1'b1;
        end
    end

    task automatic send_frame(input int ch, input int lenf, input int npay,
                              input bit good_foot, input bit hdr_in_body);
        logic [8:0]   l9;
        logic [1:0]   c2;
        logic [W-1:0] w;
        l9 = lenf[8:0];
        c2 = ch[1:0];
        w  = {16'hAAAA, {39{1'b0}}, l9};
        chq[ch].push_back(w);
        expq.push_back('{d: w, last: 1'b0, ch: c2});
        for (int j = 0; j < npay; j++) begin
            w = {8'hC0, 6'd0, c2, j[15:0], 32'h0BADF00D ^ j};
            if (hdr_in_body && j == 0) w[W-1 -: 16] = 16'hAAAA;
            chq[ch].push_back(w);
            expq.push_back('{d: w, last: 1'b0, ch: c2});
        end
        w = {16'hF0F0, 14'd0, c2, 16'h0000, (good_foot ? 16'h5555 : 16'h1111)};
        chq[ch].push_back(w);
        expq.push_back('{d: w, last: 1'b1, ch: c2});
    endtask

    function automatic bit all_idle();
        bit b;
        b = (expq.size() == 0) && !bus.oVALID;
        for (int k = 0; k < N; k++) if (chq[k].size() != 0) b = 0;
        return b;
    endfunction

    task automatic wait_drain(input string nm);
        int c;
        c = 0;
        while (!all_idle() && c < 3000) begin
            @(posedge clk);
            c++;
        end
        repeat (3) @(posedge clk);
        #2;
        chk({nm, "_drain_timeout"}, (c >= 3000) ? 64'd1 : 64'd0, 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    int e0, o0, a0, c;

    initial begin
        for (int k = 0; k < N; k++) acc_cnt[k] = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ovalid", {63'd0, bus.oVALID}, 64'd0);
        chk("rst_dout",   bus.DOUT, {W{1'b1}});
        chk("rst_olast",  {63'd0, bus.oLAST}, 64'd0);
        chk("rst_curch",  {62'd0, bus.CUR_CH}, 64'd0);
        chk("rst_perr",   {63'd0, bus.PROTO_ERR}, 64'd0);
        chk("rst_oready", {60'd0, bus.oREADY}, 64'd0);
        rst = 1'b0;

        // 1) single frame on ch0, header-like word inside the body
        o0 = out_cnt;
        send_frame(0, 3, 3, 1, 1);
        wait_drain("t1");
        chk("t1_words", 64'(out_cnt - o0), 64'd5);
        chk("t1_err", 64'(err_seen), 64'd0);

        // 2) all channels hold headers at once; round-robin from reset pointer
        do_reset();
        @(posedge clk); #2;
        for (int k = 0; k < N; k++) send_frame(k, 2 + k, 2 + k, 1, 0);
        wait_drain("t2");
        chk("t2_err", 64'(err_seen), 64'd0);

        // 3) downstream ready toggling every cycle
        toggle = 1'b1;
        o0 = out_cnt;
        send_frame(1, 6, 6, 1, 0);
        wait_drain("t3");
        toggle = 1'b0;
        chk("t3_words", 64'(out_cnt - o0), 64'd8);
        chk("t3_err", 64'(err_seen), 64'd0);

        // 4) oversize length clamps to 200 payload words
        o0 = out_cnt;
        send_frame(2, 250, 200, 1, 0);
        wait_drain("t4");
        chk("t4_words", 64'(out_cnt - o0), 64'd202);
        chk("t4_err", 64'(err_seen), 64'd1);

        // 5) stray non-header word flushed in idle
        o0 = out_cnt;
        a0 = acc_cnt[2];
        chq[2].push_back(64'h0000_0000_0000_1234);
        repeat (6) @(posedge clk);
        #2;
        chk("t5_flushed", 64'(acc_cnt[2] - a0), 64'd1);
        chk("t5_no_out", 64'(out_cnt - o0), 64'd0);
        chk("t5_err", 64'(err_seen), 64'd2);

        // zero-length frame: header followed directly by footer
        o0 = out_cnt;
        send_frame(3, 0, 0, 1, 0);
        wait_drain("t7");
        chk("t7_words", 64'(out_cnt - o0), 64'd2);
        chk("t7_err", 64'(err_seen), 64'd2);

        // bad footer marker: word forwarded, error pulse
        o0 = out_cnt;
        send_frame(0, 1, 1, 0, 0);
        wait_drain("t8");
        chk("t8_words", 64'(out_cnt - o0), 64'd3);
        chk("t8_err", 64'(err_seen), 64'd3);

        // 6) reset in the middle of a body
        o0 = out_cnt;
        send_frame(0, 20, 20, 1, 0);
        c = 0;
        while (out_cnt < o0 + 5 && c < 200) begin
            @(posedge clk);
            c++;
        end
        chk("t6_start_timeout", (c >= 200) ? 64'd1 : 64'd0, 64'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_ovalid", {63'd0, bus.oVALID}, 64'd0);
        chk("t6_dout", bus.DOUT, {W{1'b1}});
        chq[0].delete();
        expq.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        o0 = out_cnt;
        send_frame(1, 2, 2, 1, 0);
        wait_drain("t6");
        chk("t6_words", 64'(out_cnt - o0), 64'd4);
        chk("t6_err", 64'(err_seen), 64'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
